// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants for the transmit and receive sides
package uart_pkg;

  // 50 MHz system clock divided down to 9600 baud
  localparam int CLKS_PER_BIT_DEFAULT = 5208;

  // Character width on the serial line
  localparam int DATA_BITS = 8;

  // Transmit frame sequencing; PARITY is only visited when parity is built in
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Even parity bit: XOR of all data bits
  function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous first-word-fall-through byte FIFO for the UART transmitter
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  // Full/empty come from the occupancy count, so pointers can simply wrap
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Next storage, pointer and occupancy values for this cycle's push/pop
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset discards buffered bytes
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Byte storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - buffered 8N1 UART transmitter; UART_TX_PARITY_EN adds an even parity bit
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic [7:0]                    Data,
  input  logic                          Valid,
  output logic                          Ready,
  output logic                          Tx,
  output logic                          Busy,
  output logic [$clog2(FIFO_DEPTH):0]   FifoCount
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_BITS - 1);

  tx_state_t              state_q, state_d;
  logic [BW-1:0]          baud_q, baud_d;
  logic [IW-1:0]          bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q, parity_d;
`endif

  logic                   fifo_push;
  logic                   fifo_pop;
  logic [7:0]             fifo_dout;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   bit_end;

  assign Ready     = !fifo_full;
  assign fifo_push = Valid && Ready;
  assign bit_end   = (baud_q == BAUD_LAST);
  assign Tx        = tx_q;
  assign FifoCount = fifo_count;
  assign Busy      = (state_q != IDLE) || (fifo_count != '0);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (Clk),
    .rst   (Rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (Data),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State and datapath registers; reset abandons any frame and idles the line high
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Next state, baud timing, bit sequencing and FIFO pop; a new byte is loaded
  // straight from IDLE or at the end of STOP so frames run back-to-back
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    if (state_q != IDLE) begin
      baud_d = bit_end ? '0 : baud_q + BW'(1);
    end
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          baud_d   = '0;
          state_d  = START;
`ifdef UART_TX_PARITY_EN
          parity_d = even_parity(fifo_dout);
`endif
        end
      end
      START: begin
        if (bit_end) begin
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + IW'(1);
          if (bit_idx_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            state_d  = START;
`ifdef UART_TX_PARITY_EN
            parity_d = even_parity(fifo_dout);
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Line level for the coming cycle, registered so Tx is glitch-free
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx decoding the serial line against queued bytes
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CYC = NBITS * CPB;

  logic       Clk   = 1'b0;
  logic       Rst   = 1'b1;
  logic [7:0] Data  = 8'h00;
  logic       Valid = 1'b0;
  logic       Ready;
  logic       Tx;
  logic       Busy;
  logic [2:0] FifoCount;

  int checks = 0;
  int errors = 0;

  byte unsigned exp_q[$];
  int  frames_done  = 0;
  int  mon_idx      = 0;
  int  mon_last_gap = -1;
  bit  mon_in_frame = 1'b0;
  bit  saw_full     = 1'b0;

  always #5 Clk = ~Clk;

  uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Data      (Data),
    .Valid     (Valid),
    .Ready     (Ready),
    .Tx        (Tx),
    .Busy      (Busy),
    .FifoCount (FifoCount)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Serial level of bit slot k of the frame carrying byte b
  function automatic logic exp_bit(input byte unsigned b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return 1'((b >> (k - 1)) & 1);
    if (k == NBITS - 1) return 1'b1;
    return 1'($countones(b) % 2);
  endfunction

  // Decodes Tx sample by sample and compares each whole frame to the queued byte
  task automatic monitor();
    logic r;
    int   gap = 0;
    int   bad;
    logic samp [FRAME_CYC];
    byte unsigned b;
    forever begin
      @(posedge Clk);
      r = Rst;
      @(negedge Clk);
      if (r) begin
        mon_in_frame = 1'b0;
        mon_idx      = 0;
        gap          = 0;
      end else if (!mon_in_frame) begin
        if (Tx === 1'b0) begin
          mon_in_frame = 1'b1;
          samp[0]      = Tx;
          mon_idx      = 1;
          mon_last_gap = gap;
          gap          = 0;
        end else begin
          gap++;
        end
      end else begin
        samp[mon_idx] = Tx;
        mon_idx++;
        if (mon_idx == FRAME_CYC) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL frame_unexpected actual=frame expected=no_frame");
          end else begin
            b   = exp_q.pop_front();
            bad = -1;
            for (int i = 0; i < FRAME_CYC; i++) begin
              if (bad < 0 && samp[i] !== exp_bit(b, i / CPB)) bad = i;
            end
            if (bad >= 0) begin
              errors++;
              $display("FAIL frame byte=%02h sample=%0d actual=%b expected=%b",
                       b, bad, samp[bad], exp_bit(b, bad / CPB));
            end
          end
          mon_in_frame = 1'b0;
          mon_idx      = 0;
          frames_done++;
        end
      end
    end
  endtask

  // Presents a byte and holds Valid until it is accepted; leaves Valid high
  task automatic push(input byte unsigned b);
    Data  = b;
    Valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      #1;
      check("ready_vs_count", Ready, (FifoCount != 3'(DEPTH)));
      if (FifoCount == 3'(DEPTH)) saw_full = 1'b1;
      if (Ready) begin
        exp_q.push_back(b);
        @(negedge Clk);
        return;
      end
      @(negedge Clk);
    end
    check("push_timeout", 0, 1);
  endtask

  task automatic wait_frames(input int target);
    int limit;
    int t;
    limit = (target - frames_done + DEPTH + 2) * FRAME_CYC + 100;
    t = 0;
    while (frames_done < target && t < limit) begin
      @(negedge Clk);
      #1;
      t++;
    end
    check("frames_timeout", (frames_done >= target), 1);
  endtask

  task automatic stimulus();
    int target;
    int t;
    byte unsigned b;

    repeat (2) @(negedge Clk);
    #1;
    check("rst_tx", Tx, 1);
    check("rst_ready", Ready, 1);
    check("rst_busy", Busy, 0);
    check("rst_count", FifoCount, 0);
    Rst = 1'b0;

    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      #1;
      check("idle_tx", Tx, 1);
      check("idle_ready", Ready, 1);
      check("idle_busy", Busy, 0);
      check("idle_count", FifoCount, 0);
    end

    // Single 'A' with latency and Busy release
    target = frames_done + 1;
    push(8'h41);
    Valid = 1'b0;
    #1;
    check("lat_pre_tx", Tx, 1);
    check("lat_pre_busy", Busy, 1);
    check("lat_pre_count", FifoCount, 1);
    @(negedge Clk);
    #1;
    check("lat_start_tx", Tx, 0);
    check("lat_start_count", FifoCount, 0);
    wait_frames(target);
    check("busy_in_stop", Busy, 1);
    @(negedge Clk);
    #1;
    check("busy_drop", Busy, 0);
    check("idle_after_a", Tx, 1);

    // Back-to-back frames
    target = frames_done + 2;
    push(8'h48);
    push(8'h4F);
    Valid = 1'b0;
    wait_frames(target);
    check("b2b_gap", mon_last_gap, 0);

    // Six bytes with Valid held: FIFO fills and backpressures
    saw_full = 1'b0;
    target = frames_done + 6;
    for (int i = 0; i < 6; i++) push(8'($urandom));
    Valid = 1'b0;
    wait_frames(target);
    check("saw_full", saw_full, 1);
    check("six_drained", exp_q.size(), 0);

    // Reset during data bit 3 of 0x55
    push(8'h55);
    Valid = 1'b0;
    t = 0;
    while (!(mon_in_frame && mon_idx >= 3 * CPB + CPB + 1) && t < 200) begin
      @(negedge Clk);
      #1;
      t++;
    end
    check("reach_bit3", t < 200, 1);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    check("midrst_tx", Tx, 1);
    check("midrst_count", FifoCount, 0);
    check("midrst_busy", Busy, 0);
    exp_q.delete();
    for (int i = 0; i < 2 * CPB; i++) begin
      @(negedge Clk);
      #1;
      check("midrst_idle_tx", Tx, 1);
    end
    target = frames_done + 1;
    push(8'h0D);
    Valid = 1'b0;
    wait_frames(target);

`ifdef UART_TX_PARITY_EN
    target = frames_done + 2;
    push(8'h07);
    Valid = 1'b0;
    wait_frames(target - 1);
    push(8'h03);
    Valid = 1'b0;
    wait_frames(target);
`endif

    // Random bytes with random spacing
    target = frames_done + 10;
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 50)) @(negedge Clk);
      b = 8'($urandom);
      push(b);
      Valid = 1'b0;
    end
    wait_frames(target);

    @(negedge Clk);
    #1;
    check("end_queue_empty", exp_q.size(), 0);
    check("end_busy", Busy, 0);
    check("end_tx", Tx, 1);
    check("end_count", FifoCount, 0);
  endtask

  initial begin
    fork
      monitor();
      begin
        stimulus();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
      begin
        repeat (60000) @(posedge Clk);
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
      end
    join_any
  end

endmodule
